// File: rtl/cpu_pkg.sv
// Shared definitions for param_cpu_core: opcodes, FSM state encoding,
// flag bit positions and small decode helpers used by the core and the ALU.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_SHL  = 4'hD;
  localparam logic [3:0] OP_SHR  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  // Bit positions inside the {N,C,Z} flag vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

  // Opcodes whose ALU flags are committed; everything else preserves flags.
  function automatic logic op_sets_flags(input logic [3:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_ADDI, OP_SHL, OP_SHR: r = 1'b1;
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

  // Opcodes that write rd in WRITEBACK.
  function automatic logic op_writes_reg(input logic [3:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV,
      OP_LDI, OP_LD, OP_ADDI, OP_SHL, OP_SHR: r = 1'b1;
      default:                               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/param_cpu_core_if.sv
// Memory preload port of param_cpu_core.
//   load_en   : write strobe (honoured only while the core is IDLE or HALT)
//   load_sel  : 0 = instruction memory, 1 = data memory
//   load_addr : word address (truncated for data memory)
//   load_data : word to write (low bits only for data memory)
// master drives the port (loader / bench), slave is the core.
interface param_cpu_core_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);
  logic               load_en;
  logic               load_sel;
  logic [PC_W-1:0]    load_addr;
  logic [INSTR_W-1:0] load_data;

  modport master (output load_en, load_sel, load_addr, load_data);
  modport slave  (input  load_en, load_sel, load_addr, load_data);
endinterface

// File: rtl/alu_p.sv
// Combinational ALU of param_cpu_core.
//   a      : operand A (reg[rd])
//   b      : operand B (reg[rs])
//   imm    : immediate field
//   op     : opcode
//   result : ALU result, modulo 2^DATA_W
//   flags  : candidate {N,C,Z}; the core decides whether to commit them
module alu_p #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        flags
);
  import cpu_pkg::*;

  logic [DATA_W:0] wide_s;
  logic            carry_s;

  // Result and carry/borrow per opcode; the extra MSB of wide_s holds carry or borrow.
  always_comb begin
    wide_s  = {(DATA_W+1){1'b0}};
    carry_s = 1'b0;
    result  = a;
    case (op)
      OP_ADD: begin
        wide_s  = {1'b0, a} + {1'b0, b};
        result  = wide_s[DATA_W-1:0];
        carry_s = wide_s[DATA_W];
      end
      OP_SUB: begin
        // Top bit of the widened difference is set exactly when a < b unsigned.
        wide_s  = {1'b0, a} - {1'b0, b};
        result  = wide_s[DATA_W-1:0];
        carry_s = wide_s[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = b;
      OP_LDI:  result = imm;
      OP_ADDI: begin
        wide_s  = {1'b0, a} + {1'b0, imm};
        result  = wide_s[DATA_W-1:0];
        carry_s = wide_s[DATA_W];
      end
      OP_SHL: begin
        result  = {a[DATA_W-2:0], 1'b0};
        carry_s = a[DATA_W-1];
      end
      OP_SHR: begin
        result  = {1'b0, a[DATA_W-1:1]};
        carry_s = a[0];
      end
      default: result = a;
    endcase
  end

  // Flag vector derived from the selected result.
  always_comb begin
    flags         = 3'b000;
    flags[FLAG_N] = result[DATA_W-1];
    flags[FLAG_C] = carry_s;
    flags[FLAG_Z] = (result == {DATA_W{1'b0}});
  end

endmodule

// File: rtl/param_cpu_core.sv
// Parametrised multi-cycle CPU core.
//   clk          : rising-edge clock
//   reset        : asynchronous active-low reset
//   run          : start/resume pulse, honoured in IDLE or HALT
//   ld           : memory preload port (slave side)
//   dbg_reg_sel  : register observed on dbg_reg_data (combinational)
//   dbg_mem_addr : data word observed on dbg_mem_data (combinational)
//   pc, flags    : program counter and {N,C,Z}
//   busy, halted : high in FETCH..WRITEBACK / in HALT
//   instr_count  : retired instructions, saturating at 16'hFFFF
// Instruction fields from MSB: opcode[4], rd[RA_W], rs[RA_W], imm[DATA_W].
module param_cpu_core #(
  parameter int DATA_W     = 8,
  parameter int NUM_REGS   = 4,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  param_cpu_core_if.slave               ld,
  input  logic [$clog2(NUM_REGS)-1:0]   dbg_reg_sel,
  input  logic [$clog2(DMEM_DEPTH)-1:0] dbg_mem_addr,
  output logic [DATA_W-1:0]             dbg_reg_data,
  output logic [DATA_W-1:0]             dbg_mem_data,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic [2:0]                    flags,
  output logic                          busy,
  output logic                          halted,
  output logic [15:0]                   instr_count
);
  import cpu_pkg::*;

  localparam int RA_W    = $clog2(NUM_REGS);
  localparam int PC_W    = $clog2(IMEM_DEPTH);
  localparam int DA_W    = $clog2(DMEM_DEPTH);
  localparam int INSTR_W = 4 + 2*RA_W + DATA_W;

  logic [INSTR_W-1:0] imem_r [IMEM_DEPTH];
  logic [DATA_W-1:0]  dmem_r [DMEM_DEPTH];
  logic [DATA_W-1:0]  regs_r [NUM_REGS];

  state_e             state_r;
  logic [INSTR_W-1:0] ir_r;
  logic [DATA_W-1:0]  op_a_r;
  logic [DATA_W-1:0]  op_b_r;
  logic [DATA_W-1:0]  result_r;

  logic [3:0]         op_s;
  logic [RA_W-1:0]    rd_s;
  logic [RA_W-1:0]    rs_s;
  logic [DATA_W-1:0]  imm_s;
  logic [DATA_W-1:0]  alu_result_s;
  logic [2:0]         alu_flags_s;
  logic               load_ok_s;
  logic [PC_W-1:0]    pc_inc_s;
  logic [PC_W-1:0]    pc_next_s;
  logic [15:0]        count_next_s;

  assign op_s  = ir_r[INSTR_W-1 -: 4];
  assign rd_s  = ir_r[INSTR_W-5 -: RA_W];
  assign rs_s  = ir_r[INSTR_W-5-RA_W -: RA_W];
  assign imm_s = ir_r[DATA_W-1:0];

  // Preload is accepted only while the core is parked and out of reset.
  assign load_ok_s = reset && ld.load_en && ((state_r == S_IDLE) || (state_r == S_HALT));

  assign dbg_reg_data = regs_r[dbg_reg_sel];
  assign dbg_mem_data = dmem_r[dbg_mem_addr];

  assign count_next_s = (instr_count == 16'hFFFF) ? instr_count : instr_count + 16'd1;

  alu_p #(.DATA_W(DATA_W)) u_alu (
    .a      (op_a_r),
    .b      (op_b_r),
    .imm    (imm_s),
    .op     (op_s),
    .result (alu_result_s),
    .flags  (alu_flags_s)
  );

  // Sequential pc with explicit wrap for non power-of-two depths.
  always_comb begin
    if (pc == PC_W'(IMEM_DEPTH-1)) begin
      pc_inc_s = {PC_W{1'b0}};
    end else begin
      pc_inc_s = pc + PC_W'(1);
    end
  end

  // Next pc at writeback: a taken jump wins over the increment; JZ tests the current Z.
  always_comb begin
    if ((op_s == OP_JMP) || ((op_s == OP_JZ) && flags[FLAG_Z])) begin
      pc_next_s = PC_W'(imm_s);
    end else begin
      pc_next_s = pc_inc_s;
    end
  end

  // Memory writes: preload port and ST in MEM. No reset, so contents survive reset.
  always_ff @(posedge clk) begin
    if (load_ok_s && !ld.load_sel) begin
      imem_r[ld.load_addr] <= ld.load_data;
    end
    if (load_ok_s && ld.load_sel) begin
      dmem_r[ld.load_addr[DA_W-1:0]] <= ld.load_data[DATA_W-1:0];
    end else if (reset && (state_r == S_MEM) && (op_s == OP_ST)) begin
      dmem_r[DA_W'(imm_s)] <= op_a_r;
    end
  end

  // Control FSM with registered status outputs and architectural state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      pc          <= {PC_W{1'b0}};
      flags       <= 3'b000;
      instr_count <= 16'd0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      ir_r        <= {INSTR_W{1'b0}};
      op_a_r      <= {DATA_W{1'b0}};
      op_b_r      <= {DATA_W{1'b0}};
      result_r    <= {DATA_W{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      case (state_r)
        S_IDLE, S_HALT: begin
          // A load in the same cycle as run takes priority; run is dropped.
          if (run && !ld.load_en) begin
            state_r <= S_FETCH;
            busy    <= 1'b1;
            halted  <= 1'b0;
          end
        end
        S_FETCH: begin
          ir_r    <= imem_r[pc];
          state_r <= S_DECODE;
        end
        S_DECODE: begin
          op_a_r  <= regs_r[rd_s];
          op_b_r  <= regs_r[rs_s];
          state_r <= S_EXEC;
        end
        S_EXEC: begin
          result_r <= alu_result_s;
          if (op_sets_flags(op_s)) begin
            flags <= alu_flags_s;
          end
          case (op_s)
            OP_LD, OP_ST: state_r <= S_MEM;
            OP_HALT: begin
              // HALT retires here; pc steps past it so run resumes at the next word.
              state_r     <= S_HALT;
              busy        <= 1'b0;
              halted      <= 1'b1;
              pc          <= pc_inc_s;
              instr_count <= count_next_s;
            end
            default: state_r <= S_WB;
          endcase
        end
        S_MEM: begin
          if (op_s == OP_LD) begin
            result_r <= dmem_r[DA_W'(imm_s)];
          end
          state_r <= S_WB;
        end
        S_WB: begin
          if (op_writes_reg(op_s)) begin
            regs_r[rd_s] <= result_r;
          end
          pc          <= pc_next_s;
          instr_count <= count_next_s;
          state_r     <= S_FETCH;
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_cpu_core.sv
// Self-checking bench for param_cpu_core (default parameters).
module tb_param_cpu_core;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [1:0]  dbg_reg_sel = 2'd0;
  logic [3:0]  dbg_mem_addr = 4'd0;
  logic [7:0]  dbg_reg_data;
  logic [7:0]  dbg_mem_data;
  logic [7:0]  pc;
  logic [2:0]  flags;
  logic        busy;
  logic        halted;
  logic [15:0] instr_count;

  int total = 0;
  int bad = 0;

  param_cpu_core_if #(.PC_W(8), .INSTR_W(16)) ld_if ();

  param_cpu_core dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .ld           (ld_if),
    .dbg_reg_sel  (dbg_reg_sel),
    .dbg_mem_addr (dbg_mem_addr),
    .dbg_reg_data (dbg_reg_data),
    .dbg_mem_data (dbg_mem_data),
    .pc           (pc),
    .flags        (flags),
    .busy         (busy),
    .halted       (halted),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [7:0][15:0] prog;
    int               reg_sel;
    logic [7:0]       exp_reg;
    logic [2:0]       exp_flags;
    int               exp_count;
    int               exp_pc;
    int               exp_cyc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [7:0][15:0] p8(
      input logic [15:0] w0 = 16'h0000, input logic [15:0] w1 = 16'h0000,
      input logic [15:0] w2 = 16'h0000, input logic [15:0] w3 = 16'h0000,
      input logic [15:0] w4 = 16'h0000, input logic [15:0] w5 = 16'h0000,
      input logic [15:0] w6 = 16'h0000, input logic [15:0] w7 = 16'h0000);
    logic [7:0][15:0] r;
    r[0] = w0; r[1] = w1; r[2] = w2; r[3] = w3;
    r[4] = w4; r[5] = w5; r[6] = w6; r[7] = w7;
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    run = 1'b0;
    ld_if.load_en = 1'b0;
    ld_if.load_sel = 1'b0;
    ld_if.load_addr = 8'd0;
    ld_if.load_data = 16'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_word(input logic sel, input logic [7:0] addr, input logic [15:0] data);
    ld_if.load_en = 1'b1;
    ld_if.load_sel = sel;
    ld_if.load_addr = addr;
    ld_if.load_data = data;
    @(negedge clk);
    ld_if.load_en = 1'b0;
  endtask

  // Pulses run and counts rising edges until halted is seen.
  task automatic run_wait(input string nm, output int cyc);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    cyc = 1;
    while (halted !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, "_halted"}, {31'd0, halted}, 32'd1);
  endtask

  task automatic read_reg(input int r, output logic [7:0] v);
    dbg_reg_sel = r[1:0];
    #1;
    v = dbg_reg_data;
  endtask

  task automatic read_mem(input int a, output logic [7:0] v);
    dbg_mem_addr = a[3:0];
    #1;
    v = dbg_mem_data;
  endtask

  task automatic apply_vec(input vec_t v);
    int cyc;
    logic [7:0] rv;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      load_word(1'b0, k[7:0], v.prog[k]);
    end
    run_wait(v.name, cyc);
    read_reg(v.reg_sel, rv);
    check({v.name, "_reg"}, {24'd0, rv}, {24'd0, v.exp_reg});
    check({v.name, "_flags"}, {29'd0, flags}, {29'd0, v.exp_flags});
    check({v.name, "_count"}, {16'd0, instr_count}, v.exp_count);
    check({v.name, "_pc"}, {24'd0, pc}, v.exp_pc);
    check({v.name, "_cycles"}, cyc, v.exp_cyc);
  endtask

  initial begin
    int cyc;
    int c;
    logic [7:0] rv;

    vecs[0]  = '{"add", p8(enc(OP_LDI,2'd1,2'd0,8'h05), enc(OP_LDI,2'd2,2'd0,8'h03),
                 enc(OP_ADD,2'd1,2'd2,8'h00), enc(OP_HALT,2'd0,2'd0,8'h00)),
                 1, 8'h08, 3'b000, 4, 4, 16};
    vecs[1]  = '{"addi_carry", p8(enc(OP_LDI,2'd0,2'd0,8'hFF), enc(OP_ADDI,2'd0,2'd0,8'h01),
                 enc(OP_HALT,2'd0,2'd0,8'h00)),
                 0, 8'h00, 3'b011, 3, 3, 12};
    vecs[2]  = '{"sub_borrow", p8(enc(OP_LDI,2'd1,2'd0,8'h01), enc(OP_SUB,2'd0,2'd1,8'h00),
                 enc(OP_HALT,2'd0,2'd0,8'h00)),
                 0, 8'hFF, 3'b110, 3, 3, 12};
    vecs[3]  = '{"xor_zero", p8(enc(OP_LDI,2'd1,2'd0,8'hAA), enc(OP_LDI,2'd2,2'd0,8'hAA),
                 enc(OP_XOR,2'd1,2'd2,8'h00), enc(OP_HALT,2'd0,2'd0,8'h00)),
                 1, 8'h00, 3'b001, 4, 4, 16};
    vecs[4]  = '{"or_neg", p8(enc(OP_LDI,2'd3,2'd0,8'h80), enc(OP_LDI,2'd2,2'd0,8'h01),
                 enc(OP_OR,2'd3,2'd2,8'h00), enc(OP_HALT,2'd0,2'd0,8'h00)),
                 3, 8'h81, 3'b100, 4, 4, 16};
    vecs[5]  = '{"and_clr_c", p8(enc(OP_LDI,2'd0,2'd0,8'hFF), enc(OP_ADDI,2'd0,2'd0,8'h01),
                 enc(OP_LDI,2'd1,2'd0,8'hF0), enc(OP_LDI,2'd2,2'd0,8'h3C),
                 enc(OP_AND,2'd1,2'd2,8'h00), enc(OP_HALT,2'd0,2'd0,8'h00)),
                 1, 8'h30, 3'b000, 6, 6, 24};
    vecs[6]  = '{"shl", p8(enc(OP_LDI,2'd2,2'd0,8'h81), enc(OP_SHL,2'd2,2'd0,8'h00),
                 enc(OP_HALT,2'd0,2'd0,8'h00)),
                 2, 8'h02, 3'b010, 3, 3, 12};
    vecs[7]  = '{"shr", p8(enc(OP_LDI,2'd2,2'd0,8'h01), enc(OP_SHR,2'd2,2'd0,8'h00),
                 enc(OP_HALT,2'd0,2'd0,8'h00)),
                 2, 8'h00, 3'b011, 3, 3, 12};
    vecs[8]  = '{"mov_keep", p8(enc(OP_LDI,2'd0,2'd0,8'hFF), enc(OP_ADDI,2'd0,2'd0,8'h01),
                 enc(OP_LDI,2'd1,2'd0,8'h07), enc(OP_MOV,2'd3,2'd1,8'h00),
                 enc(OP_HALT,2'd0,2'd0,8'h00)),
                 3, 8'h07, 3'b011, 5, 5, 20};
    vecs[9]  = '{"jz_taken", p8(enc(OP_LDI,2'd0,2'd0,8'h00), enc(OP_ADDI,2'd0,2'd0,8'h00),
                 enc(OP_JZ,2'd0,2'd0,8'h05), enc(OP_LDI,2'd1,2'd0,8'h11),
                 enc(OP_HALT,2'd0,2'd0,8'h00), enc(OP_LDI,2'd1,2'd0,8'h22),
                 enc(OP_HALT,2'd0,2'd0,8'h00)),
                 1, 8'h22, 3'b001, 5, 7, 20};
    vecs[10] = '{"jz_fall", p8(enc(OP_LDI,2'd0,2'd0,8'h01), enc(OP_ADDI,2'd0,2'd0,8'h00),
                 enc(OP_JZ,2'd0,2'd0,8'h05), enc(OP_LDI,2'd1,2'd0,8'h11),
                 enc(OP_HALT,2'd0,2'd0,8'h00), enc(OP_LDI,2'd1,2'd0,8'h22),
                 enc(OP_HALT,2'd0,2'd0,8'h00)),
                 1, 8'h11, 3'b000, 5, 5, 20};
    vecs[11] = '{"jmp", p8(enc(OP_JMP,2'd0,2'd0,8'h03), enc(OP_LDI,2'd2,2'd0,8'h99),
                 enc(OP_HALT,2'd0,2'd0,8'h00), enc(OP_LDI,2'd2,2'd0,8'h44),
                 enc(OP_HALT,2'd0,2'd0,8'h00)),
                 2, 8'h44, 3'b000, 3, 5, 12};

    // Reset state
    do_reset();
    check("rst_pc", {24'd0, pc}, 32'd0);
    check("rst_flags", {29'd0, flags}, 32'd0);
    check("rst_count", {16'd0, instr_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    for (int r = 0; r < 4; r++) begin
      read_reg(r, rv);
      check("rst_reg", {24'd0, rv}, 32'd0);
    end

    // Table-driven programs
    for (int i = 0; i < 12; i++) begin
      apply_vec(vecs[i]);
    end

    // LD/ST through data memory, 5 cycles each
    do_reset();
    load_word(1'b1, 8'd3, 16'h005A);
    load_word(1'b1, 8'd7, 16'h0000);
    load_word(1'b0, 8'd0, enc(OP_LD, 2'd2, 2'd0, 8'h03));
    load_word(1'b0, 8'd1, enc(OP_ST, 2'd2, 2'd0, 8'h07));
    load_word(1'b0, 8'd2, enc(OP_HALT, 2'd0, 2'd0, 8'h00));
    run_wait("mem", cyc);
    check("mem_cycles", cyc, 32'd14);
    read_mem(7, rv);
    check("mem_st_data", {24'd0, rv}, 32'h5A);
    read_reg(2, rv);
    check("mem_ld_reg", {24'd0, rv}, 32'h5A);
    check("mem_count", {16'd0, instr_count}, 32'd3);

    // load_en and run while busy are ignored
    do_reset();
    for (int k = 0; k < 8; k++) begin
      load_word(1'b0, k[7:0], vecs[0].prog[k]);
    end
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    ld_if.load_en = 1'b1;
    ld_if.load_sel = 1'b0;
    ld_if.load_addr = 8'd3;
    ld_if.load_data = enc(OP_LDI, 2'd3, 2'd0, 8'h77);
    run = 1'b1;
    check("race_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    ld_if.load_en = 1'b0;
    run = 1'b0;
    c = 0;
    while (halted !== 1'b1 && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("race_halted", {31'd0, halted}, 32'd1);
    check("race_cycles", c, 32'd11);
    check("race_count", {16'd0, instr_count}, 32'd4);
    read_reg(3, rv);
    check("race_r3", {24'd0, rv}, 32'd0);
    read_reg(1, rv);
    check("race_r1", {24'd0, rv}, 32'd8);

    // load_en + run together in IDLE: word written, core stays IDLE
    do_reset();
    ld_if.load_en = 1'b1;
    ld_if.load_sel = 1'b0;
    ld_if.load_addr = 8'd0;
    ld_if.load_data = enc(OP_HALT, 2'd0, 2'd0, 8'h00);
    run = 1'b1;
    @(negedge clk);
    ld_if.load_en = 1'b0;
    run = 1'b0;
    repeat (3) @(negedge clk);
    check("ldrun_busy", {31'd0, busy}, 32'd0);
    check("ldrun_halted", {31'd0, halted}, 32'd0);
    run_wait("ldrun", cyc);
    check("ldrun_cycles", cyc, 32'd4);
    check("ldrun_pc", {24'd0, pc}, 32'd1);
    check("ldrun_count", {16'd0, instr_count}, 32'd1);

    // Resume from HALT at the next pc, with a load while halted
    load_word(1'b0, 8'd1, enc(OP_LDI, 2'd0, 2'd0, 8'h05));
    load_word(1'b0, 8'd2, enc(OP_HALT, 2'd0, 2'd0, 8'h00));
    run_wait("resume", cyc);
    check("resume_cycles", cyc, 32'd8);
    read_reg(0, rv);
    check("resume_r0", {24'd0, rv}, 32'd5);
    check("resume_pc", {24'd0, pc}, 32'd3);
    check("resume_count", {16'd0, instr_count}, 32'd3);

    // pc wraps from IMEM_DEPTH-1 to 0
    do_reset();
    load_word(1'b0, 8'd0, enc(OP_LDI, 2'd1, 2'd0, 8'h01));
    load_word(1'b0, 8'd1, enc(OP_JMP, 2'd0, 2'd0, 8'hFE));
    load_word(1'b0, 8'hFE, enc(OP_HALT, 2'd0, 2'd0, 8'h00));
    load_word(1'b0, 8'hFF, enc(OP_NOP, 2'd0, 2'd0, 8'h00));
    run_wait("wrap1", cyc);
    check("wrap1_cycles", cyc, 32'd12);
    check("wrap1_pc", {24'd0, pc}, 32'hFF);
    load_word(1'b0, 8'd0, enc(OP_HALT, 2'd0, 2'd0, 8'h00));
    run_wait("wrap2", cyc);
    check("wrap2_cycles", cyc, 32'd8);
    check("wrap2_pc", {24'd0, pc}, 32'd1);
    check("wrap2_count", {16'd0, instr_count}, 32'd5);

    // Reset asserted during MEM of a ST: async abort, store lost
    do_reset();
    load_word(1'b1, 8'd3, 16'h005A);
    load_word(1'b1, 8'd9, 16'h0033);
    load_word(1'b0, 8'd0, enc(OP_LD, 2'd2, 2'd0, 8'h03));
    load_word(1'b0, 8'd1, enc(OP_ST, 2'd2, 2'd0, 8'h09));
    load_word(1'b0, 8'd2, enc(OP_HALT, 2'd0, 2'd0, 8'h00));
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_pre_busy", {31'd0, busy}, 32'd1);
    check("abort_pre_pc", {24'd0, pc}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_pc", {24'd0, pc}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_count", {16'd0, instr_count}, 32'd0);
    read_reg(2, rv);
    check("abort_r2", {24'd0, rv}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    read_mem(9, rv);
    check("abort_dmem", {24'd0, rv}, 32'h33);

    // Reload and rerun of the first program after the abort
    apply_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_cpu_core.md
Name: param_cpu_core

Overview:
- Parametrised multi-cycle successor to the 8-bit CPU top: configurable data width, register-file size, instruction- and data-memory depth.
- Explicit FETCH/DECODE/EXECUTE/MEM/WRITEBACK state machine replaces free-running PC stepping.
- Handshaked program/data load port, run/halt control, conditional branching, flags and a retired-instruction counter.
- Sits as the processor top; testbench loads memories through the load port, pulses run, then inspects registers and memory through debug ports.

Parameters:
- DATA_W, 8: datapath and register width (min 4).
- NUM_REGS, 4: register count, power of two; RA_W = clog2(NUM_REGS).
- IMEM_DEPTH, 256: instruction words; PC_W = clog2(IMEM_DEPTH).
- DMEM_DEPTH, 16: data words; DA_W = clog2(DMEM_DEPTH).
- INSTR_W is derived as 4 + 2*RA_W + DATA_W (default 16). Fields from MSB: opcode[4], rd[RA_W], rs[RA_W], imm[DATA_W].

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  start pulse; honoured only in IDLE or HALT.
- load_en  in  1  write strobe for memory preload; honoured only in IDLE or HALT.
- load_sel  in  1  0 = instruction memory, 1 = data memory.
- load_addr  in  PC_W  load address; truncated to DA_W for data memory.
- load_data  in  INSTR_W  load word; low DATA_W bits used for data memory.
- dbg_reg_sel  in  RA_W  register to observe.
- dbg_mem_addr  in  DA_W  data word to observe.
- dbg_reg_data  out  DATA_W  combinational register read.
- dbg_mem_data  out  DATA_W  combinational data-memory read.
- pc  out  PC_W  program counter.
- flags  out  3  {N,C,Z}.
- busy  out  1  high in FETCH..WRITEBACK.
- halted  out  1  high in HALT.
- instr_count  out  16  retired instructions, saturating.

Behaviour:
- Reset (async assert, synchronous release):
  - pc=0, registers=0, flags=0, instr_count=0, state=IDLE, busy=0, halted=0.
  - Memories are not cleared.
- States:
  - IDLE: run -> FETCH.
  - FETCH: ir <= imem[pc] -> DECODE.
  - DECODE: latch operand A = reg[rd], operand B = reg[rs] -> EXECUTE.
  - EXECUTE: ALU result and flags latched; LD/ST -> MEM; HALT -> HALT; otherwise -> WRITEBACK.
  - MEM: ST writes dmem[imm[DA_W-1:0]] <= reg[rd]; LD latches the read -> WRITEBACK.
  - WRITEBACK: register write, pc update, instr_count++ -> FETCH.
  - HALT: run -> FETCH with pc retained (resume); load_en permitted.
- Latency: 4 cycles per instruction; LD/ST take 5; HALT retires in EXECUTE and increments instr_count there.
- Opcodes:
  - 0 NOP; 1 ADD; 2 SUB (rd-rs); 3 AND; 4 OR; 5 XOR.
  - 6 MOV rd<=rs; 7 LDI rd<=imm; 8 LD; 9 ST; A ADDI rd<=rd+imm.
  - B JMP pc<=imm[PC_W-1:0]; C JZ (jump if Z=1).
  - D SHL rd<=rd<<1, C = old MSB; E SHR rd<=rd>>1, C = old LSB; F HALT.
- Flag update rules:
  - Only ADD, SUB, ADDI, AND, OR, XOR, SHL and SHR update flags; all others preserve them.
  - ADD/ADDI: C = carry out of DATA_W. SUB: C = borrow (1 when rd < rs unsigned).
  - AND/OR/XOR: C=0.
  - Z = (result==0); N = result MSB.
- Width: all arithmetic is modulo 2^DATA_W; imm is truncated to PC_W for jumps and DA_W for memory.
- PC: pc+1 wraps from IMEM_DEPTH-1 to 0. Jumps take precedence over increment.
- instr_count saturates at 16'hFFFF.
- Simultaneous events:
  - load_en and run in the same IDLE cycle: load is performed, run is ignored.
  - run or load_en while busy: ignored, no side effect.
- Reset mid-instruction: aborts immediately and no partial register write occurs; a memory write is lost unless its clock edge precedes the reset assertion.
- Register 0 is a general register (not hardwired).

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams (OP_NOP..OP_HALT);
  - state encoding (S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT);
  - flag bit indices.
- One sub-module alu_p (parameter DATA_W): combinational; inputs a, b, imm, op; outputs result and {N,C,Z}. It is instantiated once in EXECUTE.

Test Plan:
- Arithmetic: load LDI r1,5; LDI r2,3; ADD r1,r2; HALT, then run -> r1=8, flags=000, instr_count=4, halted=1, 16 cycles from run to halted.
- Carry/zero: LDI r0,FF; ADDI r0,1 -> r0=00, Z=1, C=1. Then SUB r0(0),r1(1) -> r0=FF, N=1, C=1, Z=0.
- Memory: preload dmem[3]=0x5A; LD r2,[3]; ST r2,[7]; HALT -> dbg_mem_data@7=5A, LD/ST each take 5 cycles.
- Branch:
  - LDI r0,0; ADDI r0,0; JZ 6 -> pc=6 next fetch;
  - with Z=0, JZ falls through to pc+1;
  - JMP to IMEM_DEPTH-1 containing NOP -> pc wraps to 0.
- Control races:
  - load_en while busy -> imem unchanged;
  - load_en+run in IDLE -> word written, state stays IDLE;
  - run from HALT resumes at the next pc.
- Reset: assert reset low during MEM of ST -> state=IDLE, all regs 0, pc=0 asynchronously; a reload and rerun reproduces the first test's results.
